// File: rtl/mult_div_unit_if.sv
// Issue/result bundle between decoder-side logic and the multiply/divide unit.
// The master drives operands and MTHI/MTLO strobes; the slave returns busy/done and HI/LO.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] srcA;
    logic [WIDTH-1:0] srcB;
    logic             hiWrite;
    logic             loWrite;
    logic [WIDTH-1:0] writeData;
    logic             busy;
    logic             done;
    logic             divZero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, srcA, srcB, hiWrite, loWrite, writeData,
        input  busy, done, divZero, hi, lo
    );

    modport slave (
        input  start, op, srcA, srcB, hiWrite, loWrite, writeData,
        output busy, done, divZero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiply / restoring divide owning HI/LO; fixed 33-edge latency start->done.
// No backpressure: busy stalls the decoder, and start or MTHI/MTLO seen while busy are dropped.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_div_unit_if.slave  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] RUN    = 2'd1;
    localparam logic [1:0] FINISH = 2'd2;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             is_div_q, is_div_d;
    logic             neg_res_q, neg_res_d;
    logic             neg_rem_q, neg_rem_d;
    logic             b_zero_q, b_zero_d;
    logic [WIDTH-1:0] a_raw_q, a_raw_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dz_q, dz_d;

    logic             signed_op;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;

    // op[0] clear selects the signed variants (MULT, DIV)
    assign signed_op = ~bus.op[0];
    assign a_neg     = signed_op & bus.srcA[WIDTH-1];
    assign b_neg     = signed_op & bus.srcB[WIDTH-1];
    assign a_mag     = a_neg ? (WIDTH'(0) - bus.srcA) : bus.srcA;
    assign b_mag     = b_neg ? (WIDTH'(0) - bus.srcB) : bus.srcB;

    // Multiply: acc holds the running upper half, quo shifts the multiplier out / product in.
    assign mul_sum   = {1'b0, acc_q} + (quo_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});

    // Divide: acc is the partial remainder, quo shifts the dividend out / quotient in.
    assign div_shift = {acc_q, quo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, mcand_q};

    assign prod      = {acc_q, quo_q};
    assign prod_fix  = neg_res_q ? ((2*WIDTH)'(0) - prod) : prod;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        b_zero_d  = b_zero_q;
        a_raw_d   = a_raw_q;
        mcand_d   = mcand_q;
        acc_d     = acc_q;
        quo_d     = quo_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        dz_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.hiWrite) hi_d = bus.writeData;
                if (bus.loWrite) lo_d = bus.writeData;
                if (bus.start) begin
                    state_d   = RUN;
                    cnt_d     = '0;
                    is_div_d  = bus.op[1];
                    neg_res_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
                    b_zero_d  = (bus.srcB == '0);
                    a_raw_d   = bus.srcA;
                    mcand_d   = bus.op[1] ? b_mag : a_mag;
                    quo_d     = bus.op[1] ? a_mag : b_mag;
                    acc_d     = '0;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!div_diff[WIDTH]) begin
                        acc_d = div_diff[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        acc_d = div_shift[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    quo_d = {mul_sum[0], quo_q[WIDTH-1:1]};
                end
                if (cnt_q == LAST_CNT) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
                cnt_d   = '0;
                done_d  = 1'b1;
                if (is_div_q) begin
                    if (b_zero_q) begin
                        hi_d = a_raw_q;
                        lo_d = '1;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = neg_res_q ? (WIDTH'(0) - quo_q) : quo_q;
                        hi_d = neg_rem_q ? (WIDTH'(0) - acc_q) : acc_q;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            b_zero_q  <= 1'b0;
            a_raw_q   <= '0;
            mcand_q   <= '0;
            acc_q     <= '0;
            quo_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            b_zero_q  <= b_zero_d;
            a_raw_q   <= a_raw_d;
            mcand_q   <= mcand_d;
            acc_q     <= acc_d;
            quo_q     <= quo_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
        end
    end

    assign bus.busy    = (state_q != IDLE);
    assign bus.done    = done_q;
    assign bus.divZero = dz_q;
    assign bus.hi      = hi_q;
    assign bus.lo      = lo_q;
endmodule
